// File: rtl/f_delay_fifo_if.sv
// rtl/f_delay_fifo_if.sv - write/read handshake bundle for f_delay_fifo
interface f_delay_fifo_if #(
  parameter int pSIZE  = 2,
  parameter int pDEPTH = 16
);
  logic                      i_wr_en;
  logic [pSIZE-1:0]          i_wr_data;
  logic                      o_full;
  logic                      o_afull;
  logic                      o_rd_valid;
  logic                      i_rd_ready;
  logic [pSIZE-1:0]          o_rd_data;
  logic [$clog2(pDEPTH):0]   o_count;
  logic                      o_ovf;
  logic                      i_ovf_clr;

  modport master (
    output i_wr_en, i_wr_data, i_rd_ready, i_ovf_clr,
    input  o_full, o_afull, o_rd_valid, o_rd_data, o_count, o_ovf
  );

  modport slave (
    input  i_wr_en, i_wr_data, i_rd_ready, i_ovf_clr,
    output o_full, o_afull, o_rd_valid, o_rd_data, o_count, o_ovf
  );
endinterface

// File: rtl/f_delay_fifo.sv
// rtl/f_delay_fifo.sv - FWFT FIFO behind the delay line; F_DELAY_FIFO_OVF_EN adds a sticky overflow flag
module f_delay_fifo #(
  parameter int pSIZE         = 2,
  parameter int pDEPTH        = 16,
  parameter int pAFULL_MARGIN = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  f_delay_fifo_if.slave bus
);
  localparam int AW = $clog2(pDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(pDEPTH);
  localparam logic [CW-1:0] AFULL_TH_C = CW'(pDEPTH - pAFULL_MARGIN);

  logic [pSIZE-1:0] mem [pDEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop, push, drop;

  assign bus.o_full     = (count_q == DEPTH_C);
  assign bus.o_afull    = (count_q >= AFULL_TH_C);
  assign bus.o_rd_valid = (count_q != '0);
  assign bus.o_count    = count_q;
  assign bus.o_rd_data  = mem[rd_ptr_q];

  always_comb begin
    pop      = bus.o_rd_valid & bus.i_rd_ready;
    // a full FIFO still takes a write when the head leaves in the same cycle
    push     = bus.i_wr_en & (~bus.o_full | pop);
    drop     = bus.i_wr_en & bus.o_full & ~pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage is deliberately not reset
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= bus.i_wr_data;
  end

`ifdef F_DELAY_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (drop)               ovf_d = 1'b1;
    else if (bus.i_ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end

  assign bus.o_ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = bus.i_ovf_clr | drop;
  assign bus.o_ovf  = 1'b0;
`endif
endmodule

// File: tb/tb_f_delay_fifo.sv
// tb/tb_f_delay_fifo.sv - randomized and directed checks of f_delay_fifo against a queue model
module tb_f_delay_fifo;
  localparam int SZ = 8;
  localparam int DP = 4;
  localparam int MG = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [SZ-1:0] model_q[$];
  logic          model_ovf = 1'b0;

  f_delay_fifo_if #(.pSIZE(SZ), .pDEPTH(DP)) bus ();

  f_delay_fifo #(.pSIZE(SZ), .pDEPTH(DP), .pAFULL_MARGIN(MG)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = model_q.size();
    check({tag, " count"}, 32'(bus.o_count), 32'(n));
    check({tag, " valid"}, 32'(bus.o_rd_valid), 32'(n != 0));
    check({tag, " full"},  32'(bus.o_full), 32'(n == DP));
    check({tag, " afull"}, 32'(bus.o_afull), 32'(n >= DP - MG));
    check({tag, " ovf"},   32'(bus.o_ovf), 32'(model_ovf));
    if (n != 0) check({tag, " data"}, 32'(bus.o_rd_data), 32'(model_q[0]));
  endtask

  // Drives one cycle of inputs, advances the model by the FIFO rules, then checks after the edge.
  task automatic step(input string tag, input logic wr, input logic [SZ-1:0] d,
                      input logic rdy, input logic clr);
    int  n;
    logic do_pop, do_push;
    bus.i_wr_en    = wr;
    bus.i_wr_data  = d;
    bus.i_rd_ready = rdy;
    bus.i_ovf_clr  = clr;
    n       = model_q.size();
    do_pop  = (n > 0) && rdy;
    do_push = wr && ((n < DP) || do_pop);
`ifdef F_DELAY_FIFO_OVF_EN
    if (wr && (n == DP) && !do_pop) model_ovf = 1'b1;
    else if (clr)                   model_ovf = 1'b0;
`endif
    if (do_pop)  void'(model_q.pop_front());
    if (do_push) model_q.push_back(d);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    bus.i_wr_en    = 1'b0;
    bus.i_wr_data  = '0;
    bus.i_rd_ready = 1'b0;
    bus.i_ovf_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;

    step("single_wr", 1'b1, 8'hA5, 1'b0, 1'b0);
    step("single_rd", 1'b0, 8'h00, 1'b1, 1'b0);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DP; i++) step("fill", 1'b1, 8'(r * 4 + i + 1), 1'b0, 1'b0);
      for (int i = 0; i < DP; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    end

    for (int i = 0; i < DP; i++) step("fill2", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step("full_pushpop", 1'b1, 8'h55, 1'b1, 1'b0);
    step("overflow", 1'b1, 8'h99, 1'b0, 1'b0);
    step("ovf_hold", 1'b0, 8'h00, 1'b0, 1'b0);
    step("ovf_setwins", 1'b1, 8'h98, 1'b0, 1'b1);
    step("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DP; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) step("empty_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    step("after_empty", 1'b1, 8'h3C, 1'b0, 1'b0);
    step("after_empty_rd", 1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    #3;
    bus.i_wr_en = 1'b0;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    model_ovf = 1'b0;
    check_outputs("async_rst");
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("post_rst");
    step("post_rst_wr", 1'b1, 8'hC3, 1'b0, 1'b0);
    step("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      int wr_pct;
      wr_pct = ((i / 200) % 2 == 0) ? 75 : 35;
      step("random",
           $urandom_range(0, 99) < wr_pct,
           8'($urandom),
           $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 5);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
